// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for two result pipes (ALU, load) into a single register-file
// write port, plus the pending-destination scoreboard cleared by those writes.
module reg_wb_arbiter #(
  parameter int REG_FILE_BITS = 5,
  parameter int REG_FILE_SIZE = 1 << REG_FILE_BITS,
  parameter int REG_SIZE      = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [REG_FILE_BITS-1:0] req0_num,
  input  logic [REG_SIZE-1:0]      req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [REG_FILE_BITS-1:0] req1_num,
  input  logic [REG_SIZE-1:0]      req1_data,
  output logic                     rf_we,
  output logic [REG_FILE_BITS-1:0] rf_write_num,
  output logic [REG_SIZE-1:0]      rf_input_data,
  input  logic                     sb_set,
  input  logic [REG_FILE_BITS-1:0] sb_num,
  input  logic [REG_FILE_BITS-1:0] query_num1,
  input  logic [REG_FILE_BITS-1:0] query_num2,
  output logic                     busy1,
  output logic                     busy2,
  output logic [REG_FILE_SIZE-1:0] busy_mask
);

  // prio_q: 0 -> req0 wins a tie, 1 -> req1 wins a tie
  logic                     prio_q, prio_d;
  logic                     we_q, we_d;
  logic [REG_FILE_BITS-1:0] num_q, num_d;
  logic [REG_SIZE-1:0]      data_q, data_d;
  logic [REG_FILE_SIZE-1:0] busy_q, busy_d;

  logic                     grant0, grant1, accept;
  logic [REG_FILE_BITS-1:0] acc_num;
  logic [REG_SIZE-1:0]      acc_data;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~prio_q;
        grant1 = prio_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;
  assign acc_num    = grant1 ? req1_num  : req0_num;
  assign acc_data   = grant1 ? req1_data : req0_data;

  always_comb begin
    prio_d = prio_q;
    if (grant0)      prio_d = 1'b1;
    else if (grant1) prio_d = 1'b0;

    // Writes to register 0 are accepted but dropped; outputs hold their last values.
    we_d   = accept && (acc_num != '0);
    num_d  = we_d ? acc_num  : num_q;
    data_d = we_d ? acc_data : data_q;

    // Clear first, then set, so a newer producer of the same register wins.
    busy_d = busy_q;
    if (we_d)                       busy_d[acc_num] = 1'b0;
    if (sb_set && (sb_num != '0))   busy_d[sb_num]  = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q <= 1'b0;
      we_q   <= 1'b0;
      num_q  <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      prio_q <= prio_d;
      we_q   <= we_d;
      num_q  <= num_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign rf_we         = we_q;
  assign rf_write_num  = num_q;
  assign rf_input_data = data_q;
  assign busy_mask     = busy_q;
  assign busy1         = busy_q[query_num1];
  assign busy2         = busy_q[query_num2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: inputs change 1ns after posedge,
// outputs are checked on the negedge.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_num = '0, req1_num = '0;
  logic [63:0] req0_data = '0, req1_data = '0;
  logic        rf_we;
  logic [4:0]  rf_write_num;
  logic [63:0] rf_input_data;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_num = '0;
  logic [4:0]  query_num1 = '0, query_num2 = '0;
  logic        busy1, busy2;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_num(req0_num), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_num(req1_num), .req1_data(req1_data),
    .rf_we(rf_we), .rf_write_num(rf_write_num), .rf_input_data(rf_input_data),
    .sb_set(sb_set), .sb_num(sb_num),
    .query_num1(query_num1), .query_num2(query_num2),
    .busy1(busy1), .busy2(busy2), .busy_mask(busy_mask)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sb_set     = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #2;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0 got %0d want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1 got %0d want 0", req1_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we got %0d want 0", rf_we); end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL reset_busy got %h want 0", busy_mask); end
    checks++; if (rf_write_num !== 5'd0) begin errors++; $display("FAIL reset_num got %0d want 0", rf_write_num); end
    checks++; if (rf_input_data !== 64'h0) begin errors++; $display("FAIL reset_data got %h want 0", rf_input_data); end
    step();
    step();
    idle();
    rst = 1'b0;
  endtask

  task automatic test_single();
    req0_valid = 1'b1; req0_num = 5'd5; req0_data = 64'hA5;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0 got %0d want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1 got %0d want 0", req1_ready); end
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_early got %0d want 0", rf_we); end
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL single_we got %0d want 1", rf_we); end
    checks++; if (rf_write_num !== 5'd5) begin errors++; $display("FAIL single_num got %0d want 5", rf_write_num); end
    checks++; if (rf_input_data !== 64'hA5) begin errors++; $display("FAIL single_data got %h want a5", rf_input_data); end
    step();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL single_we_drop got %0d want 0", rf_we); end
    checks++; if (rf_input_data !== 64'hA5) begin errors++; $display("FAIL single_hold got %h want a5", rf_input_data); end
    step();
  endtask

  task automatic test_round_robin();
    logic        exp0;
    logic [4:0]  prev_num;
    logic [63:0] prev_data;
    int          pulses;
    prev_num = '0; prev_data = '0; pulses = 0;
    do_reset();
    req0_valid = 1'b1; req0_num = 5'd1; req0_data = 64'h100;
    req1_valid = 1'b1; req1_num = 5'd2; req1_data = 64'h200;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      exp0 = (k % 2 == 0);
      checks++; if (req0_ready !== exp0) begin errors++; $display("FAIL rr_ready0[%0d] got %0d want %0d", k, req0_ready, exp0); end
      checks++; if (req1_ready !== !exp0) begin errors++; $display("FAIL rr_ready1[%0d] got %0d want %0d", k, req1_ready, !exp0); end
      if (k > 0) begin
        if (rf_we === 1'b1) pulses++;
        checks++; if (rf_write_num !== prev_num || rf_input_data !== prev_data) begin errors++;
          $display("FAIL rr_write[%0d] got %0d/%h want %0d/%h", k, rf_write_num, rf_input_data, prev_num, prev_data); end
      end
      prev_num  = exp0 ? 5'd1 : 5'd2;
      prev_data = exp0 ? req0_data : req1_data;
      step();
      if (exp0) req0_data = req0_data + 64'd1;
      else      req1_data = req1_data + 64'd1;
    end
    idle();
    @(negedge clk);
    if (rf_we === 1'b1) pulses++;
    checks++; if (rf_write_num !== prev_num || rf_input_data !== prev_data) begin errors++;
      $display("FAIL rr_write_last got %0d/%h want %0d/%h", rf_write_num, rf_input_data, prev_num, prev_data); end
    checks++; if (pulses != 4) begin errors++; $display("FAIL rr_pulses got %0d want 4", pulses); end
    step();
  endtask

  task automatic test_scoreboard();
    query_num1 = 5'd7;
    sb_set = 1'b1; sb_num = 5'd7;
    step();
    sb_set = 1'b0;
    @(negedge clk);
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_set got %0d want 1", busy1); end
    checks++; if (busy_mask !== 32'h80) begin errors++; $display("FAIL sb_mask got %h want 80", busy_mask); end
    step();
    req1_valid = 1'b1; req1_num = 5'd7; req1_data = 64'h77;
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL sb_ready1 got %0d want 1", req1_ready); end
    checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL sb_busy_pending got %0d want 1", busy1); end
    step();
    idle();
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_write_num !== 5'd7) begin errors++; $display("FAIL sb_write got %0d/%0d want 1/7", rf_we, rf_write_num); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_busy_clear got %0d want 0", busy1); end
    step();
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL sb_busy_after got %0d want 0", busy1); end
    step();
  endtask

  task automatic test_set_clear();
    query_num2 = 5'd9;
    sb_set = 1'b1; sb_num = 5'd3;
    step();
    sb_set = 1'b0;
    @(negedge clk);
    checks++; if (busy_mask !== 32'h8) begin errors++; $display("FAIL sc_pre got %h want 8", busy_mask); end
    step();
    req0_valid = 1'b1; req0_num = 5'd3; req0_data = 64'h33;
    sb_set = 1'b1; sb_num = 5'd3;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL sc_ready0 got %0d want 1", req0_ready); end
    step();
    idle();
    @(negedge clk);
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL sc_we got %0d want 1", rf_we); end
    checks++; if (busy_mask !== 32'h8) begin errors++; $display("FAIL sc_same_reg got %h want 8", busy_mask); end
    step();
    req0_valid = 1'b1; req0_num = 5'd3; req0_data = 64'h34;
    sb_set = 1'b1; sb_num = 5'd9;
    step();
    idle();
    @(negedge clk);
    checks++; if (busy_mask !== 32'h200) begin errors++; $display("FAIL sc_distinct got %h want 200", busy_mask); end
    checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL sc_busy2 got %0d want 1", busy2); end
    checks++; if (rf_input_data !== 64'h34) begin errors++; $display("FAIL sc_data got %h want 34", rf_input_data); end
    step();
  endtask

  task automatic test_reg0();
    req0_valid = 1'b1; req0_num = 5'd0; req0_data = 64'hFF;
    sb_set = 1'b1; sb_num = 5'd0;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0d want 1", req0_ready); end
    step();
    idle();
    @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %0d want 0", rf_we); end
    checks++; if (busy_mask !== 32'h200) begin errors++; $display("FAIL r0_busy got %h want 200", busy_mask); end
    checks++; if (rf_write_num !== 5'd3 || rf_input_data !== 64'h34) begin errors++;
      $display("FAIL r0_hold got %0d/%h want 3/34", rf_write_num, rf_input_data); end
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    sb_set = 1'b1; sb_num = 5'd3;
    step();
    sb_num = 5'd7;
    step();
    sb_set = 1'b0;
    @(negedge clk);
    checks++; if (busy_mask !== 32'h88) begin errors++; $display("FAIL rm_pre got %h want 88", busy_mask); end
    step();
    req0_valid = 1'b1; req0_num = 5'd1; req0_data = 64'h1;
    req1_valid = 1'b1; req1_num = 5'd2; req1_data = 64'h2;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL rm_first got %0d want 1", req0_ready); end
    step();
    rst = 1'b1;
    #1;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rm_we got %0d want 0", rf_we); end
    checks++; if (busy_mask !== 32'h0) begin errors++; $display("FAIL rm_busy got %h want 0", busy_mask); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL rm_ready got %0d/%0d want 0/0", req0_ready, req1_ready); end
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++;
      $display("FAIL rm_after got %0d/%0d want 1/0", req0_ready, req1_ready); end
    step();
    idle();
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_write_num !== 5'd1) begin errors++;
      $display("FAIL rm_write got %0d/%0d want 1/1", rf_we, rf_write_num); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_scoreboard();
    test_set_clear();
    test_reg0();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
